// File: rtl/sx_up_pkg.sv
// Shared constants for the upstream stream scheduler: FSM encoding, class indices, default pad byte.
package sx_up_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE   = 2'd0;
    localparam fsm_state_t ST_SELECT = 2'd1;
    localparam fsm_state_t ST_SEND   = 2'd2;
    localparam fsm_state_t ST_PAD    = 2'd3;

    localparam int CLS_CTRL = 0;
    localparam int CLS_BUSI = 1;
    localparam int CLS_CIRC = 2;

    localparam logic [7:0] PAD_BYTE_DEF = 8'h00;

endpackage

// File: rtl/sx_byte_fifo.sv
// First-word fall-through byte FIFO with registered occupancy count.
module sx_byte_fifo #(
    parameter int FIFO_AW = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic [FIFO_AW:0] count,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               wr_ok;
    logic               rd_ok;

    // Count never exceeds DEPTH, so its MSB alone flags a full FIFO.
    assign full    = count[FIFO_AW];
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (!wr_ok && rd_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sx_up_stream_sched.sv
// Upstream byte scheduler: per-class FIFOs, 40 ms byte budgets, fixed-length padded bursts.
// Statistics counters are built only when SX_UP_STAT_CNT_EN is defined.
module sx_up_stream_sched
    import sx_up_pkg::*;
#(
    parameter int         NUM_CLASS = 3,
    parameter int         FIFO_AW   = 11,
    parameter int         LEN_W     = 16,
    parameter int         CNT_W     = 32,
    parameter logic [7:0] PAD_BYTE  = PAD_BYTE_DEF
) (
    input  logic                             sys_clk_i,
    input  logic                             rst_n_i,
    input  logic                             in_start_i,
    input  logic [7:0]                       in_type_i,
    input  logic [7:0]                       in_data_i,
    input  logic                             in_valid_i,
    input  logic                             uplink_40ms_i,
    input  logic [NUM_CLASS*LEN_W-1:0]       budget_i,
    input  logic                             stat_clr_i,
    input  logic                             tx_ask_i,
    input  logic [LEN_W-1:0]                 tx_len_i,
    output logic [7:0]                       tx_data_o,
    output logic                             tx_valid_o,
    output logic                             tx_busy_o,
    output logic [NUM_CLASS*(FIFO_AW+1)-1:0] fill_o,
    output logic [NUM_CLASS*CNT_W-1:0]       pkt_cnt_o,
    output logic [CNT_W-1:0]                 drop_cnt_o
);

    localparam int CLS_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;

    logic [7:0]           type_q;
    logic [7:0]           type_eff;
    logic [NUM_CLASS-1:0] wr_req;
    logic [NUM_CLASS-1:0] pop;
    logic [NUM_CLASS-1:0] fifo_empty;
    logic [NUM_CLASS-1:0] fifo_full;
    logic [7:0]           fifo_dout  [NUM_CLASS];
    logic [FIFO_AW:0]     fifo_count [NUM_CLASS];
    logic [LEN_W-1:0]     budget_q   [NUM_CLASS];

    fsm_state_t           state_q;
    logic [CLS_W-1:0]     sel_q;
    logic [CLS_W-1:0]     found_idx;
    logic                 found;
    logic [LEN_W-1:0]     rem_q;
    logic                 busy_q;
    logic                 byte_ok;
    logic [7:0]           data_p2;
    logic                 vld_p2;

    // A byte on the start cycle already belongs to the new frame.
    assign type_eff = in_start_i ? in_type_i : type_q;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            type_q <= 8'hFF;
        end else if (in_start_i) begin
            type_q <= in_type_i;
        end
    end

    for (genvar c = 0; c < NUM_CLASS; c++) begin : g_class
        assign wr_req[c] = in_valid_i && (type_eff == 8'(c));
        assign pop[c]    = byte_ok && (sel_q == CLS_W'(c));
        assign fill_o[c*(FIFO_AW+1) +: FIFO_AW+1] = fifo_count[c];

        sx_byte_fifo #(
            .FIFO_AW (FIFO_AW)
        ) u_fifo (
            .clk     (sys_clk_i),
            .rst_n   (rst_n_i),
            .wr_en   (wr_req[c]),
            .wr_data (in_data_i),
            .rd_en   (pop[c]),
            .rd_data (fifo_dout[c]),
            .count   (fifo_count[c]),
            .empty   (fifo_empty[c]),
            .full    (fifo_full[c])
        );
    end

    // A reload on the same cycle as a decrement wins; the decrement is lost.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                budget_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                if (uplink_40ms_i) begin
                    budget_q[c] <= budget_i[c*LEN_W +: LEN_W];
                end else if (pop[c]) begin
                    budget_q[c] <= budget_q[c] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int c = NUM_CLASS - 1; c >= 0; c--) begin
            if (!fifo_empty[c] && (budget_q[c] != '0)) begin
                found     = 1'b1;
                found_idx = CLS_W'(c);
            end
        end
    end

    assign byte_ok = (state_q == ST_SEND) && !fifo_empty[sel_q] && (budget_q[sel_q] != '0);

    // p2: registered burst byte; the IDLE cycle after the last byte keeps busy high while it is shown.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            data_p2 <= 8'h00;
            vld_p2  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    vld_p2 <= 1'b0;
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (tx_ask_i && (tx_len_i != '0)) begin
                        rem_q   <= tx_len_i;
                        busy_q  <= 1'b1;
                        state_q <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    sel_q   <= found_idx;
                    state_q <= found ? ST_SEND : ST_PAD;
                end
                default: begin
                    vld_p2  <= 1'b1;
                    data_p2 <= byte_ok ? fifo_dout[sel_q] : PAD_BYTE;
                    rem_q   <= rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_q <= ST_IDLE;
                    end else if (!byte_ok) begin
                        state_q <= ST_PAD;
                    end
                end
            endcase
        end
    end

    assign tx_data_o  = data_p2;
    assign tx_valid_o = vld_p2;
    assign tx_busy_o  = busy_q;

`ifdef SX_UP_STAT_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] pkt_cnt_q [NUM_CLASS];
    logic [CNT_W-1:0] drop_cnt_q;
    logic             drop_byte;

    // Bad type yields no request; a full target FIFO refuses its request.
    assign drop_byte = in_valid_i && !(|(wr_req & ~fifo_full));

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_q <= '0;
            for (int c = 0; c < NUM_CLASS; c++) begin
                pkt_cnt_q[c] <= '0;
            end
        end else if (stat_clr_i) begin
            drop_cnt_q <= '0;
            for (int c = 0; c < NUM_CLASS; c++) begin
                pkt_cnt_q[c] <= '0;
            end
        end else begin
            if (drop_byte) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
            for (int c = 0; c < NUM_CLASS; c++) begin
                if (in_start_i && (in_type_i == 8'(c))) begin
                    pkt_cnt_q[c] <= sat_inc(pkt_cnt_q[c]);
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CLASS; c++) begin : g_pkt_out
        assign pkt_cnt_o[c*CNT_W +: CNT_W] = pkt_cnt_q[c];
    end
    assign drop_cnt_o = drop_cnt_q;
`else
    logic unused_stat;

    assign pkt_cnt_o   = '0;
    assign drop_cnt_o  = '0;
    assign unused_stat = ^{stat_clr_i, fifo_full};
`endif

endmodule

// File: tb/tb_sx_up_stream_sched.sv
// Randomized bench for sx_up_stream_sched against a queue-based model of the scheduling rules.
// Counter expectations follow SX_UP_STAT_CNT_EN.
module tb_sx_up_stream_sched;

    localparam int NC    = 3;
    localparam int AW    = 11;
    localparam int LW    = 16;
    localparam int CW    = 32;
    localparam int DEPTH = 2048;
`ifdef SX_UP_STAT_CNT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_start;
    logic [7:0]        in_type;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              uplink;
    logic [NC*LW-1:0]  budget;
    logic              stat_clr;
    logic              tx_ask;
    logic [LW-1:0]     tx_len;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_busy;
    logic [NC*(AW+1)-1:0] fill;
    logic [NC*CW-1:0]  pkt_cnt;
    logic [CW-1:0]     drop_cnt;

    sx_up_stream_sched dut (
        .sys_clk_i     (clk),
        .rst_n_i       (rst_n),
        .in_start_i    (in_start),
        .in_type_i     (in_type),
        .in_data_i     (in_data),
        .in_valid_i    (in_valid),
        .uplink_40ms_i (uplink),
        .budget_i      (budget),
        .stat_clr_i    (stat_clr),
        .tx_ask_i      (tx_ask),
        .tx_len_i      (tx_len),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .tx_busy_o     (tx_busy),
        .fill_o        (fill),
        .pkt_cnt_o     (pkt_cnt),
        .drop_cnt_o    (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mq [NC][$];
    int mbud    [NC];
    int mbudset [NC];
    int mpkt    [NC];
    int mdrop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            mbud[c] = 0;
            mpkt[c] = 0;
        end
        mdrop = 0;
    endtask

    task automatic set_budgets(input int b0, input int b1, input int b2);
        mbudset[0] = b0;
        mbudset[1] = b1;
        mbudset[2] = b2;
        budget = {LW'(b2), LW'(b1), LW'(b0)};
    endtask

    task automatic pulse_uplink();
        @(negedge clk);
        uplink = 1'b1;
        @(negedge clk);
        uplink = 1'b0;
        for (int c = 0; c < NC; c++) mbud[c] = mbudset[c];
    endtask

    task automatic stat_clear();
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        for (int c = 0; c < NC; c++) mpkt[c] = 0;
        mdrop = 0;
    endtask

    task automatic send_frame(input int typ, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_start = 1'b0;
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_start = (i == 0);
            in_type  = 8'(typ);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            if (i == 0 && typ < NC) mpkt[typ]++;
            if (typ < NC && mq[typ].size() < DEPTH) mq[typ].push_back(in_data);
            else mdrop++;
        end
        @(negedge clk);
        in_start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        for (int c = 0; c < NC; c++)
            chk({tag, "_pkt"}, pkt_cnt[c*CW +: CW], STAT_EN ? 64'(mpkt[c]) : 64'd0);
        chk({tag, "_drop"}, drop_cnt, STAT_EN ? 64'(mdrop) : 64'd0);
    endtask

    task automatic check_fill(input string tag);
        for (int c = 0; c < NC; c++)
            chk({tag, "_fill"}, fill[c*(AW+1) +: AW+1], 64'(mq[c].size()));
    endtask

    task automatic burst(input string tag, input int len, input bit mid_ask);
        logic [7:0] exp [$];
        int  sel;
        int  lat;
        int  extra;
        bit  seen;
        sel = -1;
        for (int c = NC - 1; c >= 0; c--)
            if (mq[c].size() > 0 && mbud[c] > 0) sel = c;
        for (int j = 0; j < len; j++) begin
            if (sel >= 0 && mq[sel].size() > 0 && mbud[sel] > 0) begin
                exp.push_back(mq[sel].pop_front());
                mbud[sel]--;
            end else begin
                exp.push_back(8'h00);
                sel = -1;
            end
        end
        @(negedge clk);
        tx_ask = 1'b1;
        tx_len = LW'(len);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tx_ask = 1'b0;
                chk({tag, "_busy_sel"}, tx_busy, 1);
            end
            if (tx_valid) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 3);
        if (seen) begin
            for (int j = 0; j < len; j++) begin
                if (j > 0) @(negedge clk);
                if (mid_ask && j == 1) begin
                    tx_ask = 1'b1;
                    tx_len = LW'(len);
                end else begin
                    tx_ask = 1'b0;
                end
                chk({tag, "_byte"}, {tx_busy, tx_valid, tx_data}, {1'b1, 1'b1, exp[j]});
            end
            @(negedge clk);
            tx_ask = 1'b0;
            chk({tag, "_end"}, {tx_busy, tx_valid}, 2'b00);
            extra = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (tx_valid || tx_busy) extra++;
            end
            chk({tag, "_no_extra"}, extra, 0);
        end
        check_fill(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n    = 1'b0;
        in_start = 1'b0;
        in_type  = 8'h00;
        in_data  = 8'h00;
        in_valid = 1'b0;
        uplink   = 1'b0;
        stat_clr = 1'b0;
        tx_ask   = 1'b0;
        tx_len   = '0;
        set_budgets(0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_tx", {tx_busy, tx_valid, tx_data}, 10'h000);
        check_fill("rst");
        check_stats("rst");
        rst_n = 1'b1;

        // Single class-1 frame served in order
        set_budgets(100, 100, 100);
        pulse_uplink();
        send_frame(1, 10, 1'b0);
        check_stats("f1");
        burst("b1", 10, 1'b0);

        // Class 0 runs out, remainder padded, class 2 untouched
        send_frame(0, 4, 1'b0);
        send_frame(2, 8, 1'b0);
        burst("b2", 6, 1'b0);

        // Budget exhaustion, then second ask falls through to class 2
        set_budgets(3, 100, 100);
        pulse_uplink();
        send_frame(0, 10, 1'b0);
        burst("b3", 5, 1'b0);
        burst("b4", 5, 1'b0);
        burst("b5", 6, 1'b1);

        check_stats("pre_clr");
        stat_clear();
        check_stats("clr");

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    set_budgets($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12));
                    pulse_uplink();
                end
                1, 2: send_frame($urandom_range(0, 4), $urandom_range(1, 12), 1'b1);
                3: burst("rnd", $urandom_range(1, 16), 1'($urandom_range(0, 1)));
                default: if ($urandom_range(0, 3) == 0) stat_clear();
            endcase
            check_stats("rnd");
        end

        // Reset in the middle of a burst
        set_budgets(50, 50, 50);
        pulse_uplink();
        send_frame(1, 6, 1'b0);
        @(negedge clk);
        tx_ask = 1'b1;
        tx_len = LW'(20);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tx_ask = 1'b0;
            if (tx_valid) break;
            cnt++;
        end
        chk("rb_started", cnt < 8, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rb_tx", {tx_busy, tx_valid, tx_data}, 10'h000);
        model_reset();
        check_fill("rb");
        check_stats("rb");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_valid || tx_busy) cnt++;
        end
        chk("rb_quiet", cnt, 0);

        // Overflow of class 0, then an invalid-type frame
        send_frame(0, DEPTH + 5, 1'b0);
        check_fill("ovf");
        check_stats("ovf");
        send_frame(7, 3, 1'b0);
        check_stats("bad_type");
        set_budgets(100, 100, 100);
        pulse_uplink();
        burst("b_ovf", 8, 1'b0);

        // Budgets zero: all pad
        set_budgets(0, 0, 0);
        pulse_uplink();
        burst("b_pad", 4, 1'b0);

        // Zero-length ask is a no-op
        @(negedge clk);
        tx_ask = 1'b1;
        tx_len = '0;
        @(negedge clk);
        tx_ask = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (tx_valid || tx_busy) cnt++;
        end
        chk("len0", cnt, 0);
        check_fill("end");
        check_stats("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sx_up_stream_sched.md
SX_UP_STREAM_SCHED -- requirements
Module: sx_up_stream_sched

Interface
REQ-001 SHALL have parameter NUM_CLASS, default 3, meaning number of traffic classes (ctrl, busi, circuit, ...).
REQ-002 SHALL have parameter FIFO_AW, default 11, meaning log2 of the per-class byte FIFO depth (2048).
REQ-003 SHALL have parameter LEN_W, default 16, meaning width of burst length and budget.
REQ-004 SHALL have parameter CNT_W, default 32, meaning width of statistics counters.
REQ-005 SHALL have parameter PAD_BYTE, default 8'h00, meaning filler byte sent when data runs out.
REQ-006 SHALL have port sys_clk_i, input, 1 bit: the single clock (163.84 MHz).
REQ-007 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port in_start_i, input, 1 bit: frame start pulse; in_type_i is sampled on this cycle.
REQ-009 SHALL have port in_type_i, input, 8 bits: frame class index.
REQ-010 SHALL have port in_data_i, input, 8 bits: payload byte.
REQ-011 SHALL have port in_valid_i, input, 1 bit: in_data_i qualifier.
REQ-012 SHALL have port uplink_40ms_i, input, 1 bit: frame-period pulse.
REQ-013 SHALL have port budget_i, input, NUM_CLASS*LEN_W bits: per-class byte budget per 40 ms period.
REQ-014 SHALL have port stat_clr_i, input, 1 bit: statistics clear pulse.
REQ-015 SHALL have port tx_ask_i, input, 1 bit: burst request pulse.
REQ-016 SHALL have port tx_len_i, input, LEN_W bits: burst length in bytes.
REQ-017 SHALL have port tx_data_o, output, 8 bits: burst byte.
REQ-018 SHALL have port tx_valid_o, output, 1 bit: burst byte qualifier.
REQ-019 SHALL have port tx_busy_o, output, 1 bit: burst in progress.
REQ-020 SHALL have port fill_o, output, NUM_CLASS*(FIFO_AW+1) bits: per-class FIFO occupancy.
REQ-021 SHALL have port pkt_cnt_o, output, NUM_CLASS*CNT_W bits: per-class frames accepted.
REQ-022 SHALL have port drop_cnt_o, output, CNT_W bits: bytes dropped (full FIFO or bad type).

Function
REQ-023 SHALL latch the class on in_start_i; subsequent in_valid_i bytes are written to that class's FIFO; a byte on the in_start_i cycle belongs to the new frame.
REQ-024 SHALL drop bytes whose latched type is >= NUM_CLASS, incrementing drop_cnt_o once per byte.
REQ-025 SHALL drop and count a byte arriving while the target FIFO is full, without corrupting the FIFO.
REQ-026 SHALL increment pkt_cnt_o[c] on each in_start_i with valid type c.
REQ-027 SHALL reload the remaining budget of every class from budget_i on uplink_40ms_i.
REQ-028 SHALL run the FSM IDLE -> SELECT (1 cycle) -> SEND -> IDLE; PAD is entered from SEND and returns to IDLE.
REQ-029 SHALL capture tx_len_i on tx_ask_i in IDLE.
REQ-030 SHALL ignore tx_ask_i while tx_busy_o=1.
REQ-031 SHALL treat tx_len_i=0 as a no-op that stays in IDLE.
REQ-032 SHALL, in SELECT, choose the lowest-index class with a non-empty FIFO and nonzero remaining budget; if none qualifies, go directly to PAD.
REQ-033 SHALL assert the first tx_valid_o 3 cycles after tx_ask_i, then emit exactly tx_len_i contiguous bytes, one per cycle.
REQ-034 SHALL decrement the selected class's budget per byte sent.
REQ-035 SHALL switch SEND to PAD when that class's FIFO empties or its budget reaches 0; PAD emits PAD_BYTE for the remainder.
REQ-036 SHALL let an uplink_40ms_i reload coinciding with a decrement win; that cycle's decrement is lost, and the class is not re-selected mid-burst.
REQ-037 SHALL hold tx_busy_o high from the tx_ask_i acceptance cycle through the last valid byte.
REQ-038 SHALL clear pkt_cnt_o and drop_cnt_o on stat_clr_i; an increment on the same cycle is lost.
REQ-039 SHALL saturate counters at all-ones.

Reset
REQ-040 SHALL, with rst_n_i low, asynchronously force the FSM to IDLE, FIFOs empty, budgets 0, counters 0, tx_data_o=0, tx_valid_o=0, tx_busy_o=0, and fill_o=0.
REQ-041 SHALL abort a burst truncated by reset, with no further tx_valid_o after reset release until a new tx_ask_i.

Configuration
REQ-042 SHALL compile pkt_cnt_o and drop_cnt_o counters when SX_UP_STAT_CNT_EN is defined.
REQ-043 SHALL, with SX_UP_STAT_CNT_EN undefined, tie pkt_cnt_o and drop_cnt_o to 0 and instantiate no counter logic, with dropping behaviour unchanged.

Structure
REQ-044 SHALL put FSM state encoding, the class index constants (CTRL=0, BUSI=1, CIRC=2), and the pad byte default in shared package sx_up_pkg.
REQ-045 SHALL use one sub-module, sx_byte_fifo (first-word fall-through, FIFO_AW parameter, registered count), instantiated NUM_CLASS times.

Verification
REQ-046 SHALL cover: type 1 frame of 10 bytes, budget_i all 100, 40 ms pulse, ask length 10 -> 10 class-1 bytes in order, first valid 3 cycles after ask, pkt_cnt[1]=1.
REQ-047 SHALL cover: class 0 with 4 bytes, class 2 with 8 bytes, ask length 6 -> 4 class-0 bytes then 2 x 8'h00, class 2 untouched.
REQ-048 SHALL cover: budget[0]=3, class 0 with 10 bytes, ask length 5 -> 3 data bytes + 2 pad bytes; a second ask before the next 40 ms pulse -> serves class 1/2 or all pad.
REQ-049 SHALL cover: fill class 0 to 2048 bytes then 5 more -> drop_cnt=5, fill_o[0]=2048; then a type 7 frame of 3 bytes -> drop_cnt=8.
REQ-050 SHALL cover: tx_ask_i during a burst is ignored; rst_n_i low mid-burst -> tx_valid_o drops immediately, all outputs 0.
REQ-051 SHALL cover: stat_clr_i with counters nonzero -> all 0 next cycle; SX_UP_STAT_CNT_EN undefined -> counters stay 0 throughout.
